// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the I/D memory bus arbiter: requester IDs, FSM states and
// the fixed bus attributes of the instruction port.
package mem_bus_arbiter_pkg;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_I = 2'd1,
    ARB_HOLD_D = 2'd2
  } arb_state_t;

  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter_fifo.sv
// In-order record of which port issued each outstanding bus transaction,
// so responses can be routed back without any tag on the bus.
module mem_bus_arbiter_fifo
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  req_id_t                  pushId,
  input  logic                     pop,
  output req_id_t                  head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] slots;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == (PTR_W + 1)'(DEPTH));
  assign empty  = (count == '0);
  assign head   = req_id_t'(slots[rdPtr]);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      slots <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        slots[wrPtr] <= pushId;
        wrPtr        <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the fetch (I) and memory (D) ports onto one split-handshake bus
// and routes in-order responses back to the issuing port.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ARB_IDLE   | free to pick a winner each cycle; grant on m_addr_ok
// ARB_HOLD_I | I request presented but not yet accepted; bus locked to I
// ARB_HOLD_D | D request presented but not yet accepted; bus locked to D
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_OUTST  = 4,
  parameter int D_PRIORITY = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         i_req,
  input  logic [ADDR_W-1:0]            i_addr,
  output logic                         i_addr_ok,
  output logic                         i_data_ok,
  output logic [DATA_W-1:0]            i_rdata,
  input  logic                         d_req,
  input  logic                         d_wr,
  input  logic [1:0]                   d_size,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [DATA_W-1:0]            d_wdata,
  output logic                         d_addr_ok,
  output logic                         d_data_ok,
  output logic [DATA_W-1:0]            d_rdata,
  output logic                         m_req,
  output logic                         m_wr,
  output logic [1:0]                   m_size,
  output logic [ADDR_W-1:0]            m_addr,
  output logic [DATA_W-1:0]            m_wdata,
  input  logic                         m_addr_ok,
  input  logic                         m_data_ok,
  input  logic [DATA_W-1:0]            m_rdata,
  output logic [$clog2(MAX_OUTST):0]   outstanding,
  output logic                         proto_err
);

  arb_state_t state;
  req_id_t    lastGrant;
  req_id_t    winner;
  req_id_t    busOwner;
  req_id_t    head;
  logic       busReq;
  logic       ownerD;
  logic       accept;
  logic       respValid;
  logic       full;
  logic       empty;

  always_comb begin
    winner = REQ_I;
    if (d_req && !i_req) begin
      winner = REQ_D;
    end else if (d_req && i_req) begin
      winner = (D_PRIORITY != 0 || lastGrant == REQ_I) ? REQ_D : REQ_I;
    end
  end

  // A held request keeps the bus even if the other port would now win.
  always_comb begin
    busOwner = winner;
    busReq   = 1'b0;
    case (state)
      ARB_HOLD_I: begin
        busOwner = REQ_I;
        busReq   = 1'b1;
      end
      ARB_HOLD_D: begin
        busOwner = REQ_D;
        busReq   = 1'b1;
      end
      default: busReq = !full && (i_req || d_req);
    endcase
    if (!resetn) begin
      busReq = 1'b0;
    end
  end

  assign ownerD  = (busOwner == REQ_D);
  assign m_req   = busReq;
  assign m_wr    = busReq && ownerD && d_wr;
  assign m_size  = !busReq ? 2'd0 : (ownerD ? d_size : SIZE_WORD);
  assign m_addr  = !busReq ? '0 : (ownerD ? d_addr : i_addr);
  assign m_wdata = (busReq && ownerD) ? d_wdata : '0;

  assign accept    = busReq && m_addr_ok;
  assign i_addr_ok = accept && !ownerD;
  assign d_addr_ok = accept && ownerD;

  assign respValid = resetn && m_data_ok && !empty;
  assign i_data_ok = respValid && (head == REQ_I);
  assign d_data_ok = respValid && (head == REQ_D);
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;

  mem_bus_arbiter_fifo #(
    .DEPTH (MAX_OUTST)
  ) orderFifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .pushId (busOwner),
    .pop    (respValid),
    .head   (head),
    .full   (full),
    .empty  (empty),
    .count  (outstanding)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ARB_IDLE;
      lastGrant <= REQ_I;
      proto_err <= 1'b0;
    end else begin
      if (m_data_ok && empty) begin
        proto_err <= 1'b1;
      end
      if (accept) begin
        lastGrant <= busOwner;
      end
      case (state)
        ARB_IDLE: begin
          if (busReq && !m_addr_ok) begin
            state <= ownerD ? ARB_HOLD_D : ARB_HOLD_I;
          end
        end
        ARB_HOLD_I, ARB_HOLD_D: begin
          if (m_addr_ok) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: p1 is the D-priority arbiter, p0 the round-robin one.
// Expected grants and responses are queued at issue; negedge monitors compare.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, d_req, d_wr, m_addr_ok, m_data_ok;
  logic [1:0]  d_size;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;

  logic        p1_i_addr_ok, p1_i_data_ok, p1_d_addr_ok, p1_d_data_ok;
  logic        p1_m_req, p1_m_wr, p1_proto_err;
  logic [1:0]  p1_m_size;
  logic [31:0] p1_i_rdata, p1_d_rdata, p1_m_addr, p1_m_wdata;
  logic [2:0]  p1_outstanding;

  logic        p0_i_addr_ok, p0_i_data_ok, p0_d_addr_ok, p0_d_data_ok;
  logic        p0_m_req, p0_m_wr, p0_proto_err;
  logic [1:0]  p0_m_size;
  logic [31:0] p0_i_rdata, p0_d_rdata, p0_m_addr, p0_m_wdata;
  logic [2:0]  p0_outstanding;

  typedef struct {
    logic        isD;
    logic [31:0] data;
  } resp_t;

  resp_t respQ[$];
  logic  grantQ[$];
  logic  grant0Q[$];
  bit    mon0En = 1'b0;
  int    compared = 0;
  int    mismatched = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .D_PRIORITY(1)) dut1 (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(p1_i_addr_ok),
    .i_data_ok(p1_i_data_ok), .i_rdata(p1_i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(p1_d_addr_ok), .d_data_ok(p1_d_data_ok), .d_rdata(p1_d_rdata),
    .m_req(p1_m_req), .m_wr(p1_m_wr), .m_size(p1_m_size), .m_addr(p1_m_addr),
    .m_wdata(p1_m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .m_rdata(m_rdata), .outstanding(p1_outstanding), .proto_err(p1_proto_err)
  );

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .D_PRIORITY(0)) dut0 (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(p0_i_addr_ok),
    .i_data_ok(p0_i_data_ok), .i_rdata(p0_i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(p0_d_addr_ok), .d_data_ok(p0_d_data_ok), .d_rdata(p0_d_rdata),
    .m_req(p0_m_req), .m_wr(p0_m_wr), .m_size(p0_m_size), .m_addr(p0_m_addr),
    .m_wdata(p0_m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .m_rdata(m_rdata), .outstanding(p0_outstanding), .proto_err(p0_proto_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushResp(input logic isD, input logic [31:0] data);
    resp_t r;
    r.isD  = isD;
    r.data = data;
    respQ.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  // Monitors: every grant / response the DUT shows must match the queue head.
  logic  monG;
  resp_t monR;
  always @(negedge clk) begin
    if (resetn) begin
      if (p1_i_addr_ok || p1_d_addr_ok) begin
        if (grantQ.size() == 0) check("p1 unexpected grant", {p1_i_addr_ok, p1_d_addr_ok}, 0);
        else begin
          monG = grantQ.pop_front();
          check("p1 grant", {p1_i_addr_ok, p1_d_addr_ok}, monG ? 2'b01 : 2'b10);
        end
      end
      if (p1_i_data_ok || p1_d_data_ok) begin
        if (respQ.size() == 0) check("p1 unexpected data_ok", {p1_i_data_ok, p1_d_data_ok}, 0);
        else begin
          monR = respQ.pop_front();
          check("p1 resp port", {p1_i_data_ok, p1_d_data_ok}, monR.isD ? 2'b01 : 2'b10);
          check("p1 resp data", monR.isD ? p1_d_rdata : p1_i_rdata, monR.data);
        end
      end
      if (mon0En && (p0_i_addr_ok || p0_d_addr_ok)) begin
        if (grant0Q.size() == 0) check("p0 unexpected grant", {p0_i_addr_ok, p0_d_addr_ok}, 0);
        else begin
          monG = grant0Q.pop_front();
          check("p0 grant", {p0_i_addr_ok, p0_d_addr_ok}, monG ? 2'b01 : 2'b10);
        end
      end
    end
  end

  // A requester must not withdraw while the bus is locked to it.
  always @(negedge clk) begin
    if (resetn && ((dut1.state == ARB_HOLD_I && !i_req) || (dut1.state == ARB_HOLD_D && !d_req))) begin
      compared++;
      mismatched++;
      $display("FAIL hold_drop: request withdrawn in state %0d", dut1.state);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    resetn = 0;
    repeat (2) step();
    @(negedge clk);
    check("rst outstanding", p1_outstanding, 0);
    check("rst proto_err", p1_proto_err, 0);
    check("rst m_req", p1_m_req, 0);
    check("rst p0 outstanding", p0_outstanding, 0);
    step();
    resetn = 1;

    // I only, accepted at once, data two cycles later
    i_req = 1; i_addr = 32'h100; m_addr_ok = 1;
    grantQ.push_back(REQ_I); pushResp(1'b0, 32'hAAAA0001);
    @(negedge clk);
    check("t1 m_req", p1_m_req, 1);
    check("t1 m_addr", p1_m_addr, 32'h100);
    check("t1 m_size", p1_m_size, 2);
    check("t1 m_wr", p1_m_wr, 0);
    step();
    i_req = 0; m_addr_ok = 0;
    @(negedge clk);
    check("t1 outstanding", p1_outstanding, 1);
    check("t1 no early data_ok", p1_i_data_ok, 0);
    step();
    m_data_ok = 1; m_rdata = 32'hAAAA0001;
    @(negedge clk);
    check("t1 i_data_ok", p1_i_data_ok, 1);
    check("t1 d_data_ok", p1_d_data_ok, 0);
    step();
    m_data_ok = 0;

    // Tie with D priority: D first, then I; responses follow issue order
    i_req = 1; i_addr = 32'h104; d_req = 1; d_addr = 32'h200; d_size = 2; m_addr_ok = 1;
    grantQ.push_back(REQ_D); pushResp(1'b1, 32'hBBBB0002);
    @(negedge clk);
    check("t2 m_addr D", p1_m_addr, 32'h200);
    step();
    d_req = 0;
    grantQ.push_back(REQ_I); pushResp(1'b0, 32'hBBBB0003);
    @(negedge clk);
    check("t2 m_addr I", p1_m_addr, 32'h104);
    step();
    i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hBBBB0002;
    step();
    m_rdata = 32'hBBBB0003;
    step();
    m_data_ok = 0;

    // Round-robin instance alternates; priority instance keeps granting D
    resetn = 0;
    step();
    resetn = 1; mon0En = 1;
    for (int k = 0; k < 6; k++) begin
      i_req = 1; d_req = 1; d_addr = 32'h300; i_addr = 32'h380; m_addr_ok = 1;
      m_data_ok = (k > 0); m_rdata = 32'hC000 + k;
      grant0Q.push_back((k % 2 == 0) ? REQ_D : REQ_I);
      grantQ.push_back(REQ_D);
      pushResp(1'b1, 32'hC000 + k + 1);
      step();
    end
    i_req = 0; d_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hC006;
    step();
    m_data_ok = 0;
    @(negedge clk);
    check("t3 p0 outstanding", p0_outstanding, 0);
    check("t3 p1 outstanding", p1_outstanding, 0);
    check("t3 p0 grants left", grant0Q.size(), 0);
    mon0En = 0;
    step();

    // I held for three cycles while D (higher priority) waits
    i_req = 1; i_addr = 32'h400; m_addr_ok = 0;
    @(negedge clk);
    check("t4 hold c0", p1_m_addr, 32'h400);
    step();
    d_req = 1; d_addr = 32'h500;
    @(negedge clk);
    check("t4 hold c1", p1_m_addr, 32'h400);
    check("t4 d_addr_ok held off", p1_d_addr_ok, 0);
    step();
    @(negedge clk);
    check("t4 hold c2", p1_m_addr, 32'h400);
    step();
    m_addr_ok = 1;
    grantQ.push_back(REQ_I); pushResp(1'b0, 32'hE1);
    @(negedge clk);
    check("t4 accept addr", p1_m_addr, 32'h400);
    step();
    i_req = 0;
    grantQ.push_back(REQ_D); pushResp(1'b1, 32'hE2);
    @(negedge clk);
    check("t4 D next", p1_m_addr, 32'h500);
    step();
    d_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hE1;
    step();
    m_rdata = 32'hE2;
    step();
    m_data_ok = 0;

    // Fill to MAX_OUTST, then free one slot
    for (int k = 0; k < 4; k++) begin
      d_req = 1; d_wr = 1; d_size = 0; d_addr = 32'h600 + k; d_wdata = 32'h50 + k; m_addr_ok = 1;
      grantQ.push_back(REQ_D); pushResp(1'b1, 32'hF1 + k);
      @(negedge clk);
      check("t5 m_wdata", p1_m_wdata, 32'h50 + k);
      check("t5 m_size", p1_m_size, 0);
      step();
    end
    @(negedge clk);
    check("t5 full outstanding", p1_outstanding, 4);
    check("t5 full m_req", p1_m_req, 0);
    step();
    m_data_ok = 1; m_rdata = 32'hF1;
    @(negedge clk);
    check("t5 full at pop m_req", p1_m_req, 0);
    step();
    m_rdata = 32'hF2; d_addr = 32'h604; d_wdata = 32'h54;
    grantQ.push_back(REQ_D); pushResp(1'b1, 32'hF5);
    @(negedge clk);
    check("t5 push+pop m_req", p1_m_req, 1);
    check("t5 push+pop m_addr", p1_m_addr, 32'h604);
    step();
    d_req = 0; d_wr = 0; m_addr_ok = 0; m_data_ok = 0;
    @(negedge clk);
    check("t5 outstanding after push+pop", p1_outstanding, 3);
    step();
    m_data_ok = 1;
    for (int j = 0; j < 3; j++) begin
      m_rdata = 32'hF3 + j;
      step();
    end
    m_data_ok = 0;
    @(negedge clk);
    check("t5 drained", p1_outstanding, 0);
    step();

    // Stray data_ok: sticky error, no routed response, cleared by reset
    m_data_ok = 1; m_rdata = 32'h77;
    @(negedge clk);
    check("t6 i_data_ok", p1_i_data_ok, 0);
    check("t6 d_data_ok", p1_d_data_ok, 0);
    step();
    m_data_ok = 0;
    @(negedge clk);
    check("t6 proto_err set", p1_proto_err, 1);
    step();
    @(negedge clk);
    check("t6 proto_err sticky", p1_proto_err, 1);
    step();
    resetn = 0;
    step();
    resetn = 1;
    @(negedge clk);
    check("t6 proto_err cleared", p1_proto_err, 0);
    check("t6 outstanding cleared", p1_outstanding, 0);

    check("grants left", grantQ.size(), 0);
    check("responses left", respQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
